// File: rtl/pe_network_interface.sv
// pe_network_interface: bridge between a processing element and the PE port of a four-way router.
// Outbound flits are queued in an output FIFO and injected on net_so/net_do under net_ro
// backpressure. Inbound flits are queued in an input FIFO and read by the PE through a
// 2-bit register window: 0=IN_DATA 1=IN_STATUS 2=OUT_DATA 3=OUT_STATUS.
// Build option: define NIC_POLARITY_GATE_EN to offer a flit only when net_polarity matches its
// VC tag bit; undefined, injection ignores net_polarity.
module pe_network_interface #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned VC_BIT    = 63,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned IN_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di,
  input  logic              net_polarity,
  output logic              drop_err
);

  localparam int unsigned OAW = $clog2(OUT_DEPTH);
  localparam int unsigned IAW = $clog2(IN_DEPTH);

  typedef logic [OAW-1:0]    out_ptr_t;
  typedef logic [OAW:0]      out_cnt_t;
  typedef logic [IAW-1:0]    in_ptr_t;
  typedef logic [IAW:0]      in_cnt_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam out_cnt_t OUT_FULL_CNT = out_cnt_t'(OUT_DEPTH);
  localparam in_cnt_t  IN_FULL_CNT  = in_cnt_t'(IN_DEPTH);

  // Output FIFO state
  data_t    r_out_mem [OUT_DEPTH];
  out_ptr_t r_out_wp;
  out_ptr_t r_out_rp;
  out_cnt_t r_out_cnt;

  // Input FIFO state
  data_t   r_in_mem [IN_DEPTH];
  in_ptr_t r_in_wp;
  in_ptr_t r_in_rp;
  in_cnt_t r_in_cnt;

  data_t r_d_out;
  logic  r_drop_err;

  logic w_out_full, w_out_empty, w_in_full, w_in_empty;
  logic w_out_wr, w_out_push, w_out_pop;
  logic w_in_rd, w_in_push, w_in_pop;
  logic w_gate;

  assign w_out_full  = (r_out_cnt == OUT_FULL_CNT);
  assign w_out_empty = (r_out_cnt == '0);
  assign w_in_full   = (r_in_cnt == IN_FULL_CNT);
  assign w_in_empty  = (r_in_cnt == '0);

`ifdef NIC_POLARITY_GATE_EN
  // Head-of-line flit waits for the router cycle whose polarity matches its VC tag.
  assign w_gate = (net_polarity == net_do[VC_BIT]);
`else
  assign w_gate = 1'b1;
`endif

  assign net_do = r_out_mem[r_out_rp];
  assign net_so = !w_out_empty && net_ro && w_gate;
  assign net_ri = !w_in_full;

  assign w_out_wr   = nicEn && nicWrEn && (addr == 2'd2);
  assign w_out_push = w_out_wr && !w_out_full;
  assign w_out_pop  = net_so;

  assign w_in_rd   = nicEn && !nicWrEn && (addr == 2'd0);
  assign w_in_push = net_si && net_ri;
  assign w_in_pop  = w_in_rd && !w_in_empty;

  assign d_out    = r_d_out;
  assign drop_err = r_drop_err;

  // Output FIFO storage: write at the tail on an accepted PE write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < OUT_DEPTH; i++) r_out_mem[i] <= '0;
    end else if (w_out_push) begin
      r_out_mem[r_out_wp] <= d_in;
    end
  end

  // Output FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_wp  <= '0;
      r_out_rp  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_out_push) r_out_wp <= r_out_wp + out_ptr_t'(1);
      if (w_out_pop)  r_out_rp <= r_out_rp + out_ptr_t'(1);
      unique case ({w_out_push, w_out_pop})
        2'b10:   r_out_cnt <= r_out_cnt + out_cnt_t'(1);
        2'b01:   r_out_cnt <= r_out_cnt - out_cnt_t'(1);
        default: r_out_cnt <= r_out_cnt;
      endcase
    end
  end

  // Input FIFO storage: write at the tail on an accepted router flit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < IN_DEPTH; i++) r_in_mem[i] <= '0;
    end else if (w_in_push) begin
      r_in_mem[r_in_wp] <= net_di;
    end
  end

  // Input FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_wp  <= '0;
      r_in_rp  <= '0;
      r_in_cnt <= '0;
    end else begin
      if (w_in_push) r_in_wp <= r_in_wp + in_ptr_t'(1);
      if (w_in_pop)  r_in_rp <= r_in_rp + in_ptr_t'(1);
      unique case ({w_in_push, w_in_pop})
        2'b10:   r_in_cnt <= r_in_cnt + in_cnt_t'(1);
        2'b01:   r_in_cnt <= r_in_cnt - in_cnt_t'(1);
        default: r_in_cnt <= r_in_cnt;
      endcase
    end
  end

  // PE read data: registered, holds when there is no read access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d_out <= '0;
    end else if (nicEn && !nicWrEn) begin
      unique case (addr)
        2'd0:    r_d_out <= w_in_empty ? '0 : r_in_mem[r_in_rp];
        2'd1:    r_d_out <= {{(DATA_W-2){1'b0}}, w_in_full, !w_in_empty};
        2'd2:    r_d_out <= '0;
        default: r_d_out <= {{(DATA_W-2){1'b0}}, w_out_empty, w_out_full};
      endcase
    end
  end

  // Sticky drop flag: a write while full is lost even if a pop happens on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_err <= 1'b0;
    end else if (w_out_wr && w_out_full) begin
      r_drop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_network_interface.sv
// Testbench for pe_network_interface: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the NIC.
module tb_pe_network_interface;

  localparam int unsigned OD = 4;
  localparam int unsigned ID = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [63:0] d_in = '0;
  logic [63:0] d_out;
  logic        nicEn = 1'b0;
  logic        nicWrEn = 1'b0;
  logic        net_so;
  logic        net_ro = 1'b0;
  logic [63:0] net_do;
  logic        net_si = 1'b0;
  logic        net_ri;
  logic [63:0] net_di = '0;
  logic        net_polarity = 1'b0;
  logic        drop_err;

  always #5 clk = ~clk;

  pe_network_interface #(
    .DATA_W(64), .VC_BIT(63), .OUT_DEPTH(OD), .IN_DEPTH(ID)
  ) dut (
    .clk(clk), .reset(rst_n), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_si(net_si), .net_ri(net_ri), .net_di(net_di), .net_polarity(net_polarity),
    .drop_err(drop_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: two queues plus the PE-visible registers.
  logic [63:0] oq[$];
  logic [63:0] iq[$];
  logic [63:0] m_dout = '0;
  bit          m_drop = 1'b0;

  function automatic bit m_gate(logic [63:0] f, logic pol);
`ifdef NIC_POLARITY_GATE_EN
    return pol == f[63];
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit m_so();
    if (oq.size() == 0 || !net_ro) return 1'b0;
    return m_gate(oq[0], net_polarity);
  endfunction

  function automatic bit m_ri();
    return iq.size() < ID;
  endfunction

  task automatic model_clear();
    oq.delete();
    iq.delete();
    m_dout = '0;
    m_drop = 1'b0;
  endtask

  task automatic drive(bit en, bit wr, logic [1:0] a, logic [63:0] din, bit ro, bit si,
                       logic [63:0] di, bit pol);
    @(negedge clk);
    nicEn = en; nicWrEn = wr; addr = a; d_in = din;
    net_ro = ro; net_si = si; net_di = di; net_polarity = pol;
    #1;
  endtask

  // Advance the model by one clock edge using the currently driven inputs, then let the DUT edge.
  task automatic tick();
    bit so, ofull, oempty, ifull, iempty;
    so = m_so();
    ofull = (oq.size() == OD);
    oempty = (oq.size() == 0);
    ifull = (iq.size() == ID);
    iempty = (iq.size() == 0);
    if (so) void'(oq.pop_front());
    if (nicEn && nicWrEn && addr == 2'd2) begin
      if (ofull) m_drop = 1'b1;
      else oq.push_back(d_in);
    end
    if (nicEn && !nicWrEn) begin
      case (addr)
        2'd0: m_dout = iempty ? 64'd0 : iq.pop_front();
        2'd1: m_dout = {62'd0, ifull, !iempty};
        2'd2: m_dout = 64'd0;
        default: m_dout = {62'd0, oempty, ofull};
      endcase
    end
    if (net_si && !ifull) iq.push_back(net_di);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (net_so !== 1'b0) begin n_errors++; $display("FAIL rst_so: got %b exp 0", net_so); end
    n_checks++; if (net_ri !== 1'b1) begin n_errors++; $display("FAIL rst_ri: got %b exp 1", net_ri); end
    n_checks++; if (d_out !== 64'd0) begin n_errors++; $display("FAIL rst_dout: got %h exp 0", d_out); end
    n_checks++; if (drop_err !== 1'b0) begin n_errors++; $display("FAIL rst_drop: got %b exp 0", drop_err); end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_out_single();
    logic [63:0] f;
    f = 64'h0000_0001_0000_0010;
    drive(1, 1, 2'd2, f, 1, 0, '0, 0);
    n_checks++; if (net_so !== 1'b0) begin n_errors++; $display("FAIL single_so_pre: got %b exp 0", net_so); end
    tick();
    drive(0, 0, 2'd0, '0, 1, 0, '0, 0);
    n_checks++; if (net_so !== 1'b1) begin n_errors++; $display("FAIL single_so: got %b exp 1", net_so); end
    n_checks++; if (net_do !== f) begin n_errors++; $display("FAIL single_do: got %h exp %h", net_do, f); end
    tick();
    drive(1, 0, 2'd3, '0, 1, 0, '0, 0);
    n_checks++; if (net_so !== 1'b0) begin n_errors++; $display("FAIL single_so_post: got %b exp 0", net_so); end
    tick();
    n_checks++; if (d_out !== 64'h2) begin n_errors++; $display("FAIL single_status: got %h exp 2", d_out); end
  endtask

  task automatic test_polarity();
    logic [63:0] f1, g0, g1, got[$], exp[$];
    f1 = {1'b1, 31'h0, $urandom};
    drive(1, 1, 2'd2, f1, 1, 0, '0, 0);
    tick();
`ifdef NIC_POLARITY_GATE_EN
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 2'd0, '0, 1, 0, '0, 0);
      n_checks++; if (net_so !== 1'b0) begin n_errors++; $display("FAIL pol_wait: got %b exp 0", net_so); end
      tick();
    end
    drive(0, 0, 2'd0, '0, 1, 0, '0, 1);
    n_checks++; if (net_so !== 1'b1) begin n_errors++; $display("FAIL pol_match: got %b exp 1", net_so); end
    n_checks++; if (net_do !== f1) begin n_errors++; $display("FAIL pol_do: got %h exp %h", net_do, f1); end
    tick();
    drive(0, 0, 2'd0, '0, 1, 0, '0, 0);
    n_checks++; if (net_so !== 1'b0) begin n_errors++; $display("FAIL pol_once: got %b exp 0", net_so); end
    tick();
`else
    drive(0, 0, 2'd0, '0, 1, 0, '0, 0);
    n_checks++; if (net_so !== 1'b1) begin n_errors++; $display("FAIL pol_ignored: got %b exp 1", net_so); end
    n_checks++; if (net_do !== f1) begin n_errors++; $display("FAIL pol_do: got %h exp %h", net_do, f1); end
    tick();
`endif
    g0 = {1'b0, 31'h0, $urandom};
    g1 = {1'b1, 31'h0, $urandom};
    exp.push_back(g0);
    exp.push_back(g1);
    drive(1, 1, 2'd2, g0, 1, 0, '0, 1);
    tick();
    drive(1, 1, 2'd2, g1, 1, 0, '0, 0);
    if (net_so === 1'b1) got.push_back(net_do);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 2'd0, '0, 1, 0, '0, i[0] ? 1'b0 : 1'b1);
      n_checks++; if (net_so !== m_so()) begin n_errors++; $display("FAIL pol_seq_so: got %b exp %b", net_so, m_so()); end
      if (net_so === 1'b1) got.push_back(net_do);
      tick();
    end
    n_checks++; if (got.size() != 2) begin n_errors++; $display("FAIL pol_count: got %0d exp 2", got.size()); end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp[i]) begin n_errors++; $display("FAIL pol_order: got %h exp %h", got[i], exp[i]); end
    end
  endtask

  task automatic test_out_overflow();
    logic [63:0] f[5];
    logic [63:0] got[$];
    for (int i = 0; i < 5; i++) begin
      f[i] = {$urandom, $urandom};
      drive(1, 1, 2'd2, f[i], 0, 0, '0, 0);
      tick();
    end
    n_checks++; if (drop_err !== 1'b1) begin n_errors++; $display("FAIL ovf_drop: got %b exp 1", drop_err); end
    drive(1, 0, 2'd3, '0, 0, 0, '0, 0);
    tick();
    n_checks++; if (d_out !== 64'h1) begin n_errors++; $display("FAIL ovf_status: got %h exp 1", d_out); end
    for (int c = 0; c < 20; c++) begin
      drive(0, 0, 2'd0, '0, 1, 0, '0, (oq.size() != 0) ? oq[0][63] : 1'b0);
      n_checks++; if (net_so !== m_so()) begin n_errors++; $display("FAIL ovf_so: got %b exp %b", net_so, m_so()); end
      if (net_so === 1'b1) got.push_back(net_do);
      tick();
    end
    n_checks++; if (got.size() != 4) begin n_errors++; $display("FAIL ovf_count: got %0d exp 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_checks++; if (got[i] !== f[i]) begin n_errors++; $display("FAIL ovf_order: got %h exp %h", got[i], f[i]); end
    end
    n_checks++; if (drop_err !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %b exp 1", drop_err); end
  endtask

  task automatic test_reset_midrun();
    logic [63:0] f;
    for (int i = 0; i < 2; i++) begin
      f = {$urandom, $urandom};
      drive(1, 1, 2'd2, f, 0, 1, {$urandom, $urandom}, 0);
      tick();
    end
    drive(0, 0, 2'd0, '0, 1, 0, '0, oq[0][63]);
    n_checks++; if (net_so !== 1'b1) begin n_errors++; $display("FAIL mid_so_pre: got %b exp 1", net_so); end
    #2;
    rst_n = 1'b0;
    nicEn = 1'b0;
    net_si = 1'b0;
    #1;
    model_clear();
    n_checks++; if (net_so !== 1'b0) begin n_errors++; $display("FAIL mid_so: got %b exp 0", net_so); end
    n_checks++; if (net_ri !== 1'b1) begin n_errors++; $display("FAIL mid_ri: got %b exp 1", net_ri); end
    n_checks++; if (d_out !== 64'd0) begin n_errors++; $display("FAIL mid_dout: got %h exp 0", d_out); end
    n_checks++; if (drop_err !== 1'b0) begin n_errors++; $display("FAIL mid_drop: got %b exp 0", drop_err); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 2'd3, '0, 1, 0, '0, 0);
    tick();
    n_checks++; if (d_out !== 64'h2) begin n_errors++; $display("FAIL mid_status: got %h exp 2", d_out); end
    drive(1, 0, 2'd0, '0, 1, 0, '0, 0);
    tick();
    n_checks++; if (d_out !== 64'h0) begin n_errors++; $display("FAIL mid_in_empty: got %h exp 0", d_out); end
  endtask

  task automatic test_in_fill();
    logic [63:0] a[4];
    for (int i = 0; i < 4; i++) begin
      a[i] = {$urandom, $urandom};
      drive(0, 0, 2'd0, '0, 0, 1, a[i], 0);
      n_checks++; if (net_ri !== 1'b1) begin n_errors++; $display("FAIL fill_ri: got %b exp 1", net_ri); end
      tick();
    end
    drive(0, 0, 2'd0, '0, 0, 1, {$urandom, $urandom}, 0);
    n_checks++; if (net_ri !== 1'b0) begin n_errors++; $display("FAIL fill_full: got %b exp 0", net_ri); end
    tick();
    drive(1, 0, 2'd1, '0, 0, 0, '0, 0);
    tick();
    n_checks++; if (d_out !== 64'h3) begin n_errors++; $display("FAIL fill_status: got %h exp 3", d_out); end
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 2'd0, '0, 0, 0, '0, 0);
      tick();
      n_checks++;
      if (d_out !== ((i < 4) ? a[i] : 64'd0)) begin
        n_errors++; $display("FAIL fill_read%0d: got %h exp %h", i, d_out, (i < 4) ? a[i] : 64'd0);
      end
      if (i == 0) begin
        n_checks++; if (net_ri !== 1'b1) begin n_errors++; $display("FAIL fill_ri_free: got %b exp 1", net_ri); end
      end
    end
  endtask

  task automatic test_in_simul();
    logic [63:0] b[5];
    for (int i = 0; i < 5; i++) b[i] = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 2'd0, '0, 0, 1, b[i], 0);
      tick();
    end
    drive(1, 0, 2'd0, '0, 0, 1, b[3], 0);
    tick();
    n_checks++; if (d_out !== b[0]) begin n_errors++; $display("FAIL simul_head: got %h exp %h", d_out, b[0]); end
    n_checks++; if (net_ri !== 1'b1) begin n_errors++; $display("FAIL simul_ri: got %b exp 1", net_ri); end
    drive(0, 0, 2'd0, '0, 0, 1, b[4], 0);
    tick();
    n_checks++; if (net_ri !== 1'b0) begin n_errors++; $display("FAIL simul_cnt3: got %b exp 0", net_ri); end
    for (int i = 1; i < 6; i++) begin
      drive(1, 0, 2'd0, '0, 0, 0, '0, 0);
      tick();
      n_checks++;
      if (d_out !== ((i < 5) ? b[i] : 64'd0)) begin
        n_errors++; $display("FAIL simul_read%0d: got %h exp %h", i, d_out, (i < 5) ? b[i] : 64'd0);
      end
    end
  endtask

  task automatic test_random();
    bit en, wr, ro, si, pol;
    logic [1:0] a;
    for (int c = 0; c < 600; c++) begin
      en = ($urandom_range(0, 99) < 60);
      wr = $urandom_range(0, 1);
      a = 2'($urandom_range(0, 3));
      ro = ($urandom_range(0, 99) < 60);
      si = ($urandom_range(0, 99) < 50);
      pol = $urandom_range(0, 1);
      drive(en, wr, a, {$urandom, $urandom}, ro, si, {$urandom, $urandom}, pol);
      n_checks++; if (net_so !== m_so()) begin n_errors++; $display("FAIL rnd_so c%0d: got %b exp %b", c, net_so, m_so()); end
      if (m_so()) begin
        n_checks++; if (net_do !== oq[0]) begin n_errors++; $display("FAIL rnd_do c%0d: got %h exp %h", c, net_do, oq[0]); end
      end
      n_checks++; if (net_ri !== m_ri()) begin n_errors++; $display("FAIL rnd_ri c%0d: got %b exp %b", c, net_ri, m_ri()); end
      tick();
      n_checks++; if (d_out !== m_dout) begin n_errors++; $display("FAIL rnd_dout c%0d: got %h exp %h", c, d_out, m_dout); end
      n_checks++; if (drop_err !== m_drop) begin n_errors++; $display("FAIL rnd_drop c%0d: got %b exp %b", c, drop_err, m_drop); end
    end
  endtask

  initial begin
    test_reset();
    test_out_single();
    test_polarity();
    test_out_overflow();
    test_reset_midrun();
    test_in_fill();
    test_in_simul();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
